min_queue_sched: RTL and testbench

Operation scheduler between the min-queue top-level push/pop interface and `ram_manager`. It buffers bursts of pushes in a small first-word-fall-through input FIFO and drains them into `ram_manager` one operation at a time. It grants pops only when the RAM minimum is guaranteed to be the true queue minimum. It owns the `full`, `push_wait`, `empty` and `min_valid` flags of the top level.

---
 rtl/min_queue_pkg.sv | 14 +
 rtl/min_queue_sched_fifo.sv | 52 +++++
 rtl/min_queue_sched.sv | 103 ++++++++++
 tb/tb_min_queue_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_queue_pkg.sv
// min_queue_pkg: shared record width, record type and scheduler FSM encoding.
package min_queue_pkg;

    localparam int REC_WD = 48;

    typedef logic [REC_WD-1:0] rec_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH_BUSY = 2'd1,
        POP_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/min_queue_sched_fifo.sv
// sched_fifo: first-word-fall-through buffer holding pushed records until ram_manager takes them.
module sched_fifo
    import min_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WD = REC_WD,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout,
    output logic [AW:0]   count,
    output logic          fifo_empty,
    output logic          fifo_full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WD-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr       = wr_en & ~fifo_full;
    assign w_rd       = rd_en & ~fifo_empty;
    assign dout       = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign fifo_empty = (r_count == '0);
    assign fifo_full  = (r_count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/min_queue_sched.sv
// min_queue_sched: buffers pushes, serialises push/pop operations to ram_manager, owns the queue flags.
module min_queue_sched
    import min_queue_pkg::*;
#(
    parameter int q_depth    = 1024,
    parameter int ptr_wd     = 10,
    parameter int fifo_depth = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push,
    input  logic [REC_WD-1:0] push_record,
    output logic              full,
    output logic              push_wait,
    input  logic              pop,
    output logic [REC_WD-1:0] pop_record,
    output logic              empty,
    output logic              min_valid,
    output logic              op_start,
    output logic              op_pop,
    output logic [REC_WD-1:0] op_record,
    input  logic              ram_done,
    input  logic              ram_min_valid,
    input  logic [REC_WD-1:0] ram_min_record
);

    localparam int FW = $clog2(fifo_depth);
    localparam logic [ptr_wd:0] QD = (ptr_wd+1)'(q_depth);
    localparam logic [FW:0] FIFO_FULL_CNT = (FW+1)'(fifo_depth);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ptr_wd:0]   r_cnt;
    logic [ptr_wd:0]   w_cnt_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_pop_start;
    logic              w_push_acc;
    logic              w_pop_acc;
    logic              w_push_go;
    logic [REC_WD-1:0] w_head;
    logic [FW:0]       w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    sched_fifo #(
        .DEPTH (fifo_depth),
        .WD    (REC_WD)
    ) u_fifo (
        .clk        (clk),
        .rst_b      (rst_b),
        .wr_en      (w_push_acc),
        .rd_en      (w_push_go),
        .din        (push_record),
        .dout       (w_head),
        .count      (w_fifo_count),
        .fifo_empty (w_fifo_empty),
        .fifo_full  (w_fifo_full)
    );

    assign w_push_acc = push & ~r_full & ~w_fifo_full;
    assign w_pop_acc  = pop & min_valid;
    assign min_valid  = (r_state == IDLE) & w_fifo_empty & ram_min_valid & ~r_empty;
    // A granted pop implies an empty FIFO, so the pop needs no priority term here.
    assign w_push_go  = (r_state == IDLE) & ~w_fifo_empty;

    assign full       = r_full;
    assign empty      = r_empty;
    assign push_wait  = (w_fifo_count == FIFO_FULL_CNT);
    assign pop_record = ram_min_record;
    assign op_start   = w_push_go | r_pop_start;
    assign op_pop     = r_pop_start;
    assign op_record  = w_push_go ? w_head : '0;

    assign w_cnt_nxt = (w_push_acc & ~w_pop_acc) ? r_cnt + 1'b1 :
                       (w_pop_acc & ~w_push_acc) ? r_cnt - 1'b1 : r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:                w_state_nxt = w_pop_acc ? POP_BUSY : w_push_go ? PUSH_BUSY : IDLE;
            PUSH_BUSY, POP_BUSY: w_state_nxt = ram_done ? IDLE : r_state;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_pop_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_full      <= (w_cnt_nxt == QD);
            r_empty     <= (w_cnt_nxt == '0);
            r_pop_start <= w_pop_acc;
        end
    end

endmodule

// File: tb/tb_min_queue_sched.sv
// tb_min_queue_sched: directed stimulus with a queue scoreboard of expected ram_manager operations.
module tb_min_queue_sched;

    typedef struct packed {
        logic        pop;
        logic [47:0] rec;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        push;
    logic [47:0] push_record;
    logic        full;
    logic        push_wait;
    logic        pop;
    logic [47:0] pop_record;
    logic        empty;
    logic        min_valid;
    logic        op_start;
    logic        op_pop;
    logic [47:0] op_record;
    logic        ram_done;
    logic        ram_min_valid;
    logic [47:0] ram_min_record;

    int          compared = 0;
    int          mismatched = 0;
    op_t         exp_q[$];
    logic [47:0] rq[$];
    logic        busy = 1'b0;
    logic        cur_pop = 1'b0;
    logic [47:0] cur_rec = '0;
    logic        inject_done = 1'b0;
    int          cd = 0;
    int          lat = 3;

    min_queue_sched #(
        .q_depth    (8),
        .ptr_wd     (3),
        .fifo_depth (4)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .push           (push),
        .push_record    (push_record),
        .full           (full),
        .push_wait      (push_wait),
        .pop            (pop),
        .pop_record     (pop_record),
        .empty          (empty),
        .min_valid      (min_valid),
        .op_start       (op_start),
        .op_pop         (op_pop),
        .op_record      (op_record),
        .ram_done       (ram_done),
        .ram_min_valid  (ram_min_valid),
        .ram_min_record (ram_min_record)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk48(input string nm, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every op_start must match the oldest expected operation.
    initial begin
        op_t e;
        forever begin
            @(negedge clk);
            if (rst_b && op_start) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL op_unexpected: got op_start op_pop=%0b rec=%h expected none", op_pop, op_record);
                end else begin
                    e = exp_q.pop_front();
                    chk1("op_pop", op_pop, e.pop);
                    if (!e.pop) chk48("op_record", op_record, e.rec);
                end
            end
        end
    end

    // ram_manager model: fixed latency, sorted record store, min valid only when idle.
    initial begin
        logic s_rst, s_start, s_pop, s_done;
        logic [47:0] s_rec;
        ram_done = 1'b0;
        ram_min_valid = 1'b0;
        ram_min_record = '0;
        forever begin
            @(negedge clk);
            s_rst = rst_b;
            s_start = op_start;
            s_pop = op_pop;
            s_rec = op_record;
            s_done = ram_done;
            if (s_rst && s_start) chk1("op_while_busy", busy, 1'b0);
            @(posedge clk);
            #2;
            ram_done = inject_done;
            if (!s_rst) begin
                rq.delete();
                busy = 1'b0;
            end else if (s_done && busy) begin
                if (cur_pop) void'(rq.pop_front());
                else begin
                    rq.push_back(cur_rec);
                    rq.sort();
                end
                busy = 1'b0;
            end else if (s_start) begin
                busy = 1'b1;
                cur_pop = s_pop;
                cur_rec = s_rec;
                cd = lat;
            end else if (busy) begin
                cd--;
                if (cd == 0) ram_done = 1'b1;
            end
            ram_min_valid = !busy && rq.size() > 0;
            ram_min_record = (rq.size() > 0) ? rq[0] : '0;
        end
    end

    task automatic wait_min_valid(input string nm);
        int n = 0;
        @(negedge clk);
        while (!min_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1(nm, min_valid, 1'b1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk1(nm, busy || exp_q.size() != 0, 1'b0);
    endtask

    task automatic do_pop(input logic [47:0] exp_min);
        wait_min_valid("min_valid_before_pop");
        chk48("pop_record", pop_record, exp_min);
        step();
        pop = 1'b1;
        exp_q.push_back({1'b1, 48'd0});
        step();
        pop = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        chk1("rst_full", full, 1'b0);
        chk1("rst_push_wait", push_wait, 1'b0);
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_min_valid", min_valid, 1'b0);
        chk1("rst_op_start", op_start, 1'b0);
        chk1("rst_op_pop", op_pop, 1'b0);
        chk48("rst_op_record", op_record, 48'd0);
    endtask

    initial begin
        logic [47:0] sorted [8];
        int n;
        sorted = '{48'h10, 48'h20, 48'h30, 48'h50, 48'h60, 48'h70, 48'h80, 48'h90};
        rst_b = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        push_record = '0;
        repeat (3) step();
        check_reset_outputs();
        step();
        rst_b = 1'b1;

        // single push, 3-cycle ram latency
        step();
        push = 1'b1;
        push_record = 48'h5;
        exp_q.push_back({1'b0, 48'h5});
        step();
        push = 1'b0;
        @(negedge clk);
        chk1("push_lat_op_start", op_start, 1'b1);
        chk1("push_lat_op_pop", op_pop, 1'b0);
        chk48("push_lat_op_record", op_record, 48'h5);
        wait_min_valid("min_valid_after_push");
        chk48("pop_record_single", pop_record, 48'h5);
        chk1("not_empty_single", empty, 1'b0);

        // single pop: issue latency and min_valid drop
        step();
        pop = 1'b1;
        exp_q.push_back({1'b1, 48'd0});
        step();
        pop = 1'b0;
        @(negedge clk);
        chk1("pop_lat_op_start", op_start, 1'b1);
        chk1("pop_lat_op_pop", op_pop, 1'b1);
        chk1("pop_min_valid_low", min_valid, 1'b0);
        wait_idle("idle_after_pop");
        chk1("empty_after_pop", empty, 1'b1);
        chk1("min_valid_when_empty", min_valid, 1'b0);

        // burst: the 5 pushes after a leading push hit push_wait on the last
        lat = 10;
        step();
        push = 1'b1;
        push_record = 48'h60;
        exp_q.push_back({1'b0, 48'h60});
        step();
        push_record = 48'h30;
        exp_q.push_back({1'b0, 48'h30});
        step();
        push_record = 48'h10;
        exp_q.push_back({1'b0, 48'h10});
        step();
        push_record = 48'h50;
        exp_q.push_back({1'b0, 48'h50});
        step();
        push_record = 48'h20;
        exp_q.push_back({1'b0, 48'h20});
        @(negedge clk);
        chk1("burst_push_wait_lo", push_wait, 1'b0);
        step();
        push_record = 48'h40;
        @(negedge clk);
        chk1("burst_push_wait_hi", push_wait, 1'b1);
        step();
        push = 1'b0;
        wait_idle("idle_after_burst");
        wait_min_valid("min_valid_after_burst");
        chk48("burst_min", pop_record, 48'h10);
        chk1("burst_push_wait_clear", push_wait, 1'b0);

        // pop while FIFO holds an unsorted record is refused
        lat = 4;
        step();
        push = 1'b1;
        push_record = 48'h08;
        exp_q.push_back({1'b0, 48'h08});
        step();
        push = 1'b0;
        pop = 1'b1;
        @(negedge clk);
        chk1("fifo_busy_min_valid", min_valid, 1'b0);
        chk1("fifo_busy_op_pop", op_pop, 1'b0);
        step();
        pop = 1'b0;
        wait_idle("idle_after_refused_pop");
        wait_min_valid("min_valid_after_refused_pop");
        chk48("refused_pop_min", pop_record, 48'h08);

        // simultaneous push and pop: pop first, push after ram_done
        step();
        push = 1'b1;
        pop = 1'b1;
        push_record = 48'h70;
        exp_q.push_back({1'b1, 48'd0});
        exp_q.push_back({1'b0, 48'h70});
        step();
        push = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        chk1("simul_op_start", op_start, 1'b1);
        chk1("simul_op_pop", op_pop, 1'b1);
        chk1("simul_min_valid_t1", min_valid, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            chk1("simul_min_valid_low", min_valid, 1'b0);
            n++;
        end while (!(op_start && !op_pop) && n < 50);
        chk1("simul_push_issued", op_start && !op_pop, 1'b1);
        wait_idle("idle_after_simul");
        wait_min_valid("min_valid_after_simul");
        chk48("simul_min", pop_record, 48'h10);

        // fill to capacity 8 (6 held), then drop further pushes
        step();
        push = 1'b1;
        push_record = 48'h90;
        exp_q.push_back({1'b0, 48'h90});
        step();
        push_record = 48'h80;
        exp_q.push_back({1'b0, 48'h80});
        @(negedge clk);
        chk1("fill_full_lo", full, 1'b0);
        step();
        push_record = 48'h01;
        @(negedge clk);
        chk1("fill_full_hi", full, 1'b1);
        step();
        push_record = 48'h02;
        @(negedge clk);
        chk1("fill_full_hold", full, 1'b1);
        step();
        push = 1'b0;
        wait_idle("idle_after_fill");
        chk1("full_after_fill", full, 1'b1);

        // drain: full drops the cycle after the first pop, empty after eight
        do_pop(sorted[0]);
        @(negedge clk);
        chk1("full_clear_after_pop", full, 1'b0);
        for (int i = 1; i < 8; i++) do_pop(sorted[i]);
        wait_idle("idle_after_drain");
        chk1("empty_after_drain", empty, 1'b1);
        chk1("min_valid_after_drain", min_valid, 1'b0);

        // reset during POP_BUSY, then a stray ram_done
        lat = 3;
        step();
        push = 1'b1;
        push_record = 48'h33;
        exp_q.push_back({1'b0, 48'h33});
        step();
        push = 1'b0;
        wait_idle("idle_before_reset_test");
        lat = 10;
        do_pop(48'h33);
        step();
        step();
        rst_b = 1'b0;
        step();
        step();
        rst_b = 1'b1;
        check_reset_outputs();
        step();
        inject_done = 1'b1;
        @(negedge clk);
        chk1("late_done_no_start", op_start, 1'b0);
        step();
        inject_done = 1'b0;
        @(negedge clk);
        chk1("late_done_no_start_next", op_start, 1'b0);
        chk1("late_done_empty", empty, 1'b1);
        chk1("late_done_min_valid", min_valid, 1'b0);
        chk1("scoreboard_drained", exp_q.size() != 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
